// File: rtl/display_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous data commit.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module display_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  digit_bcd,
  output logic [3:0]  anode,
  output logic        dp
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [19:0] SHOW_LAST = 20'(REFRESH_DIV - 1);
  localparam logic [19:0] GAP_LAST  = 20'(GAP_CYCLES - 1);

  state_t      state, state_nx;
  logic [1:0]  idx, idx_nx;
  logic [19:0] cnt, cnt_nx;

  logic [15:0] disp_val, disp_val_nx, pend_val;
  logic [3:0]  disp_dp, disp_dp_nx, pend_dp;
  logic        pend_flag;
  logic        commit;
  logic        blank_nx;
  logic [3:0]  nib_nx;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    if (!enable) begin
      state_nx = OFF;
      idx_nx   = 2'd0;
      cnt_nx   = 20'd0;
    end else begin
      case (state)
        OFF: begin
          state_nx = SHOW;
          idx_nx   = 2'd0;
          cnt_nx   = 20'd0;
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_nx = 20'd0;
            if (GAP_CYCLES > 0) begin
              state_nx = GAP;
            end else begin
              idx_nx = idx + 2'd1;
            end
          end else begin
            cnt_nx = cnt + 20'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_nx = SHOW;
            idx_nx   = idx + 2'd1;
            cnt_nx   = 20'd0;
          end else begin
            cnt_nx = cnt + 20'd1;
          end
        end
        default: begin
          state_nx = OFF;
          idx_nx   = 2'd0;
          cnt_nx   = 20'd0;
        end
      endcase
    end
  end

  // Commit only at a frame boundary (entering digit 0) or while dark, so a frame never tears.
  always_comb begin
    commit = pend_flag &&
             ((state == OFF) ||
              ((state_nx == SHOW) && (idx_nx == 2'd0) && !((state == SHOW) && (idx == 2'd0))));
    disp_val_nx = commit ? pend_val : disp_val;
    disp_dp_nx  = commit ? pend_dp  : disp_dp;
    nib_nx      = disp_val_nx[{idx_nx, 2'b00} +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    case (idx_nx)
      2'd3:    blank_nx = (disp_val_nx[15:12] == 4'd0)  && !disp_dp_nx[3];
      2'd2:    blank_nx = (disp_val_nx[15:8]  == 8'd0)  && !disp_dp_nx[2];
      2'd1:    blank_nx = (disp_val_nx[15:4]  == 12'd0) && !disp_dp_nx[1];
      default: blank_nx = 1'b0;
    endcase
  end
`else
  assign blank_nx = 1'b0;
`endif

  // Outputs are registered from next-state values so they line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      idx       <= 2'd0;
      cnt       <= 20'd0;
      disp_val  <= 16'd0;
      disp_dp   <= 4'd0;
      pend_val  <= 16'd0;
      pend_dp   <= 4'd0;
      pend_flag <= 1'b0;
      load_ack  <= 1'b0;
      digit_bcd <= 4'd0;
      anode     <= 4'b1111;
      dp        <= 1'b1;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      disp_val  <= disp_val_nx;
      disp_dp   <= disp_dp_nx;
      load_ack  <= commit;
      digit_bcd <= nib_nx;
      // A load coinciding with a commit stays pending for the next boundary.
      if (load) begin
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end else if (commit) begin
        pend_flag <= 1'b0;
      end
      if ((state_nx == SHOW) && !blank_nx) begin
        anode <= ~(4'b0001 << idx_nx);
        dp    <= ~disp_dp_nx[idx_nx];
      end else begin
        anode <= 4'b1111;
        dp    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench: directed scenarios then random traffic, compared each cycle
// against a frame-position reference model of the scan controller.
module tb_display_scan_controller;

  localparam int R     = 4;
  localparam int G     = 1;
  localparam int SLOT  = R + G;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  digit_bcd;
  logic [3:0]  anode;
  logic        dp;

  int n_total = 0;
  int n_pass  = 0;
  int ack_seen = 0;

  // Reference model: on/off, position within the frame, and the two data registers.
  bit          m_on;
  int          m_pos;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pflag, m_ack;

  display_scan_controller #(.REFRESH_DIV(R), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .value     (value),
    .dp_in     (dp_in),
    .load      (load),
    .load_ack  (load_ack),
    .digit_bcd (digit_bcd),
    .anode     (anode),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge();
    bit next_on;
    int next_pos;
    bit new_frame;
    bit do_commit;
    if (reset) begin
      m_on = 0; m_pos = 0; m_disp = '0; m_ddp = '0;
      m_pend = '0; m_pdp = '0; m_pflag = 0; m_ack = 0;
    end else begin
      next_on   = enable;
      next_pos  = (!enable || !m_on) ? 0 : (m_pos + 1) % FRAME;
      new_frame = enable && (!m_on || next_pos == 0);
      do_commit = m_pflag && (!m_on || new_frame);
      m_ack = do_commit;
      if (do_commit) begin
        m_disp = m_pend;
        m_ddp  = m_pdp;
      end
      if (load) begin
        m_pend = value; m_pdp = dp_in; m_pflag = 1;
      end else if (do_commit) begin
        m_pflag = 0;
      end
      m_on  = next_on;
      m_pos = next_pos;
    end
  endtask

  task automatic compare();
    int slot;
    int phase;
    bit lit;
    logic [15:0] sh;
    logic [3:0] e_anode;
    logic e_dp;
    slot  = m_on ? m_pos / SLOT : 0;
    phase = m_pos % SLOT;
    sh    = m_disp >> (4 * slot);
    lit   = m_on && (phase < R);
`ifdef LEADING_ZERO_BLANK_EN
    if (lit && slot > 0 && sh == 16'd0 && !m_ddp[slot]) lit = 0;
`endif
    e_anode = lit ? ~(4'b0001 << slot) : 4'b1111;
    e_dp    = lit ? ~m_ddp[slot] : 1'b1;
    check("anode", {12'd0, anode}, {12'd0, e_anode});
    check("dp", {15'd0, dp}, {15'd0, e_dp});
    check("digit_bcd", {12'd0, digit_bcd}, {12'd0, sh[3:0]});
    check("load_ack", {15'd0, load_ack}, {15'd0, m_ack});
    check("anode_one_low", 16'($countones(~anode) <= 1), 16'd1);
    if (load_ack) ack_seen++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model sits at frame position p; an expired bound counts as a failure.
  task automatic wait_pos(input int p);
    int k;
    for (k = 0; k < 4 * FRAME; k++) begin
      if (m_on && m_pos == p) break;
      step();
    end
    check("wait_bound", 16'(k < 4 * FRAME), 16'd1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; value = '0; dp_in = '0; load = 1'b0;
    m_on = 0; m_pos = 0; m_disp = '0; m_ddp = '0;
    m_pend = '0; m_pdp = '0; m_pflag = 0; m_ack = 0;
    #2;
    run(2);
    reset = 1'b0;
    run(2);

    // Plain scan sequence over two frames.
    enable = 1'b1;
    run(2 * FRAME);

    // Load during digit 2 slot; commit only at next frame start.
    wait_pos(2 * SLOT + 1);
    value = 16'h1234; dp_in = 4'b0010; load = 1'b1;
    ack_seen = 0;
    step();
    load = 1'b0;
    run(FRAME + 5);
    check("ack_count_1234", 16'(ack_seen), 16'd1);

    // Drop enable mid digit 1, then re-enable.
    wait_pos(SLOT + 2);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(FRAME);

    // Two loads before one boundary: only the later is committed, one ack.
    wait_pos(SLOT);
    ack_seen = 0;
    value = 16'h0001; dp_in = 4'b0000; load = 1'b1; step();
    load = 1'b0; step();
    value = 16'h0099; load = 1'b1; step();
    load = 1'b0;
    wait_pos(2);
    check("ack_count_double", 16'(ack_seen), 16'd1);

    // Load coincident with commit cycle waits for the following boundary.
    wait_pos(2 * SLOT);
    ack_seen = 0;
    value = 16'h0055; load = 1'b1; step();
    load = 1'b0;
    wait_pos(FRAME - 1);
    value = 16'h0066; load = 1'b1; step();
    load = 1'b0;
    run(FRAME + 2);
    check("ack_count_coincident", 16'(ack_seen), 16'd2);

    // Leading-zero patterns.
    value = 16'h0007; dp_in = 4'b0000; load = 1'b1; step();
    load = 1'b0; run(2 * FRAME);
    value = 16'h0000; load = 1'b1; step();
    load = 1'b0; run(2 * FRAME);
    value = 16'h00AF; dp_in = 4'b0100; load = 1'b1; step();
    load = 1'b0; run(2 * FRAME);

    // Reset mid-load discards pending data with no ack.
    wait_pos(SLOT + 1);
    value = 16'h9876; load = 1'b1; reset = 1'b1; step();
    load = 1'b0; reset = 1'b0;
    ack_seen = 0;
    run(FRAME + 5);
    check("ack_after_reset", 16'(ack_seen), 16'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      load   = ($urandom_range(0, 7) == 0);
      value  = 16'($urandom);
      dp_in  = 4'($urandom);
      reset  = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; load = 1'b0;
    run(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
